regfile_wb: RTL and testbench

//   Y86-64 register file and architectural status unit, directly downstream of the writeback stage.

---
 rtl/regfile_wb.sv | 121 ++++++++++++
 tb/tb_regfile_wb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// Y86-64 register file with sticky machine status and retired-instruction counter.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle commit data onto the read ports.
module regfile_wb #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREG   = 15,
    parameter logic [3:0]  RNONE  = 4'hF,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wb_valid_i,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        dstE_i,
    input  logic [3:0]        dstM_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [DATA_W-1:0] valM_i,
    input  logic              instr_valid_i,
    input  logic              imem_error_i,
    input  logic              dmem_error_i,
    input  logic [3:0]        srcA_i,
    input  logic [3:0]        srcB_i,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o,
    output logic [2:0]        stat_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_cnt_o
);

    typedef enum logic [2:0] {
        ST_AOK = 3'd1,
        ST_HLT = 3'd2,
        ST_ADR = 3'd3,
        ST_INS = 3'd4
    } stat_t;

    localparam logic [3:0] ICODE_HALT = 4'h0;

    stat_t             stat;
    stat_t             fault;
    logic              go;
    logic              we_e;
    logic              we_m;
    logic [DATA_W-1:0] regs [NREG];

    // Fault classification, highest priority first; ST_AOK means no fault.
    always_comb begin
        fault = ST_AOK;
        if (dmem_error_i || imem_error_i) begin
            fault = ST_ADR;
        end else if (!instr_valid_i) begin
            fault = ST_INS;
        end else if (icode_i == ICODE_HALT) begin
            fault = ST_HLT;
        end
    end

    assign go   = wb_valid_i && (stat == ST_AOK) && (fault == ST_AOK);
    assign we_e = go && (dstE_i != RNONE);
    assign we_m = go && (dstM_i != RNONE);

    // Status FSM: leaves AOK on the first faulting or HALT instruction, then absorbs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stat <= ST_AOK;
        end else if (wb_valid_i && (stat == ST_AOK) && (fault != ST_AOK)) begin
            stat <= fault;
        end
    end

    // Register writes; the valM write comes second so it wins on a shared destination.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we_e) begin
                regs[dstE_i] <= valE_i;
            end
            if (we_m) begin
                regs[dstM_i] <= valM_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retired_cnt_o <= '0;
        end else if (go) begin
            retired_cnt_o <= retired_cnt_o + CNT_W'(1);
        end
    end

    // Read ports.
    always_comb begin
        valA_o = '0;
        valB_o = '0;
        if (srcA_i != RNONE) begin
            valA_o = regs[srcA_i];
        end
        if (srcB_i != RNONE) begin
            valB_o = regs[srcB_i];
        end
`ifdef REGFILE_BYPASS_EN
        if (we_m && (srcA_i == dstM_i)) begin
            valA_o = valM_i;
        end else if (we_e && (srcA_i == dstE_i)) begin
            valA_o = valE_i;
        end
        if (we_m && (srcB_i == dstM_i)) begin
            valB_o = valM_i;
        end else if (we_e && (srcB_i == dstE_i)) begin
            valB_o = valE_i;
        end
`endif
    end

    assign stat_o   = stat;
    assign halted_o = (stat != ST_AOK);

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: stimulus pushes reference-model expectations,
// two monitors pop and compare read ports (mid-cycle) and status/counter (after each edge).
module tb_regfile_wb;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_valid = 1'b0;
    logic [3:0]    icode = 4'h1;
    logic [3:0]    dstE = 4'hF;
    logic [3:0]    dstM = 4'hF;
    logic [63:0]   valE = '0;
    logic [63:0]   valM = '0;
    logic          instr_valid = 1'b1;
    logic          imem_error = 1'b0;
    logic          dmem_error = 1'b0;
    logic [3:0]    srcA = 4'hF;
    logic [3:0]    srcB = 4'hF;
    logic [63:0]   valA;
    logic [63:0]   valB;
    logic [2:0]    stat;
    logic          halted;
    logic [CW-1:0] retired;

    regfile_wb #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .wb_valid_i(wb_valid), .icode_i(icode),
        .dstE_i(dstE), .dstM_i(dstM), .valE_i(valE), .valM_i(valM),
        .instr_valid_i(instr_valid), .imem_error_i(imem_error), .dmem_error_i(dmem_error),
        .srcA_i(srcA), .srcB_i(srcB), .valA_o(valA), .valB_o(valB),
        .stat_o(stat), .halted_o(halted), .retired_cnt_o(retired)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0]    rd_q [$];
    logic [CW+2:0]   st_q [$];

    // Reference model state: architectural registers 0..14, id 15 always 0.
    logic [63:0]   m_regs [16];
    int            m_stat;
    logic [CW-1:0] m_cnt;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [3:0] src, input bit go,
                                               input logic [3:0] dE, input logic [3:0] dM,
                                               input logic [63:0] vE, input logic [63:0] vM);
        if (src == 4'hF) return 64'h0;
        if (BYPASS && go && dM != 4'hF && src == dM) return vM;
        if (BYPASS && go && dE != 4'hF && src == dE) return vE;
        return m_regs[src];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_stat = 1;
        m_cnt  = '0;
    endtask

    task automatic drive(input bit rst, input bit wbv, input logic [3:0] ic,
                         input logic [3:0] dE, input logic [3:0] dM,
                         input logic [63:0] vE, input logic [63:0] vM,
                         input bit iv, input bit ie, input bit de,
                         input logic [3:0] sA, input logic [3:0] sB);
        int f;
        bit go;
        @(negedge clk);
        rst_n = !rst; wb_valid = wbv; icode = ic; dstE = dE; dstM = dM;
        valE = vE; valM = vM; instr_valid = iv; imem_error = ie; dmem_error = de;
        srcA = sA; srcB = sB;
        if (rst) model_reset();
        if (de || ie)        f = 3;
        else if (!iv)        f = 4;
        else if (ic == 4'h0) f = 2;
        else                 f = 1;
        go = !rst && wbv && m_stat == 1 && f == 1;
        rd_q.push_back({model_read(sA, go, dE, dM, vE, vM), model_read(sB, go, dE, dM, vE, vM)});
        if (!rst && wbv && m_stat == 1) begin
            if (f != 1) begin
                m_stat = f;
            end else begin
                if (dE != 4'hF) m_regs[dE] = vE;
                if (dM != 4'hF) m_regs[dM] = vM;
                m_cnt = m_cnt + 1'b1;
            end
        end
        st_q.push_back({3'(m_stat), m_cnt});
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 4'h2, 4'h1, 4'h2, 64'hDEAD, 64'hBEEF, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
    endtask

    task automatic commit(input logic [3:0] dE, input logic [3:0] dM,
                          input logic [63:0] vE, input logic [63:0] vM,
                          input logic [3:0] sA, input logic [3:0] sB);
        drive(1'b0, 1'b1, 4'h6, dE, dM, vE, vM, 1'b1, 1'b0, 1'b0, sA, sB);
    endtask

    task automatic bubble(input logic [3:0] sA, input logic [3:0] sB);
        drive(1'b0, 1'b0, 4'h6, 4'hF, 4'hF, '0, '0, 1'b1, 1'b0, 1'b0, sA, sB);
    endtask

    // Read-port monitor: inputs settle at negedge, sampled 2 time units later.
    initial begin : rd_mon
        logic [127:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                chk("valA", valA, e[127:64]);
                chk("valB", valB, e[63:0]);
            end
        end
    end

    // Status/counter monitor: sampled just after each rising edge.
    initial begin : st_mon
        logic [CW+2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("stat", 64'(stat), 64'(e[CW+2:CW]));
                chk("halted", 64'(halted), 64'(e[CW+2:CW] != 3'd1));
                chk("retired", 64'(retired), 64'(e[CW-1:0]));
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        do_reset();
        bubble(4'h3, 4'h0);
        commit(4'h3, 4'hF, 64'h1234, 64'h9999, 4'h0, 4'h3);
        bubble(4'h3, 4'hF);
        commit(4'h4, 4'h4, 64'hAA, 64'hBB, 4'h4, 4'h3);
        bubble(4'h4, 4'h3);
        commit(4'h7, 4'hF, 64'h55, 64'h0, 4'h3, 4'h7);
        bubble(4'h0, 4'h7);
        drive(1'b0, 1'b0, 4'h6, 4'h8, 4'h9, 64'h11, 64'h22, 1'b1, 1'b1, 1'b0, 4'hF, 4'h8);
        bubble(4'h8, 4'h9);
        drive(1'b0, 1'b1, 4'h0, 4'h5, 4'hF, 64'h77, 64'h0, 1'b1, 1'b0, 1'b0, 4'h5, 4'hF);
        commit(4'h6, 4'hF, 64'h66, 64'h0, 4'h5, 4'h6);
        bubble(4'h6, 4'h5);
        do_reset();
        commit(4'h1, 4'hF, 64'h10, 64'h0, 4'hF, 4'hF);
        drive(1'b0, 1'b1, 4'h5, 4'h2, 4'h3, 64'h1, 64'h2, 1'b0, 1'b0, 1'b1, 4'h1, 4'h2);
        bubble(4'h2, 4'h3);
        do_reset();
        // Long fault-free run wraps the narrow counter.
        for (int i = 0; i < 20; i++)
            commit(4'(i % 15), 4'hF, 64'(i + 100), 64'h0, 4'(i % 15), 4'((i + 14) % 15));

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                drive(1'b0,
                      $urandom_range(9) < 8,
                      ($urandom_range(29) == 0) ? 4'h0 : 4'($urandom_range(15, 1)),
                      ($urandom_range(3) == 0) ? 4'hF : 4'($urandom_range(14)),
                      ($urandom_range(3) == 0) ? 4'hF : 4'($urandom_range(14)),
                      {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(59) != 0,
                      $urandom_range(79) == 0,
                      $urandom_range(79) == 0,
                      4'($urandom_range(15)), 4'($urandom_range(15)));
            end
        end
        bubble(4'hF, 4'hF);
        @(negedge clk);
        #4;
        n_vec++;
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d read and %0d status entries left, expected 0", rd_q.size(), st_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
